uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
- REQ-001: Parameter DEPTH, 16, receive FIFO depth in bytes; power of 2, minimum 2.
- REQ-002: Parameter CNT_W, 8, width of each error counter.
- REQ-003: clock  in  1  single clock for all logic; all state changes on its rising edge.
- REQ-004: reset  in  1  asynchronous, active-high reset.
- REQ-005: rx_data  in  8  received byte from the UART receiver.
- REQ-006: rx_dataready  in  1  receiver holds a byte.
- REQ-007: rx_framing  in  1  receiver framing-error flag.
- REQ-008: rx_overrun  in  1  receiver overrun flag.
- REQ-009: rx_readdata  out  1  one-cycle acknowledge pulse to the receiver.
- REQ-010: rx_clearerr  out  1  one-cycle error-clear pulse to the receiver.
- REQ-011: out_data  out  8  FIFO head byte.
- REQ-012: out_valid  out  1  FIFO non-empty.
- REQ-013: out_ready  in  1  consumer pop request.
- REQ-014: fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.
- REQ-015: framing_cnt  out  CNT_W  count of discarded framing-error bytes.
- REQ-016: overrun_cnt  out  CNT_W  count of overrun events.
- REQ-017: flush  in  1  synchronous FIFO clear.
- REQ-018: stat_clear  in  1  synchronous clear of both error counters.

Function
- REQ-019: FSM has two states, IDLE and WAIT; all outputs are registered.
- REQ-020: IDLE, rx_dataready=1, rx_framing=1: discard the byte; pulse rx_readdata and rx_clearerr together for one cycle; framing_cnt+1; go to WAIT.
- REQ-021: IDLE, rx_dataready=1, rx_framing=0, fifo_count<DEPTH: push rx_data; pulse rx_readdata for one cycle; go to WAIT.
- REQ-022: Same case with rx_overrun=1 additionally: push rx_data; pulse rx_clearerr with rx_readdata; overrun_cnt+1.
- REQ-023: When framing and overrun are both set, REQ-020 applies; overrun_cnt also increments.
- REQ-024: IDLE, rx_dataready=1, FIFO full, no framing error: no acknowledge, no push; stay in IDLE (byte is left in the receiver).
- REQ-025: WAIT: stay until rx_dataready=0 is sampled, then go to IDLE; no pulses are issued in WAIT.
- REQ-026: Latency: rx_readdata, rx_clearerr, fifo_count, out_valid and counters update on the same edge that samples the qualifying rx_dataready.
- REQ-027: out_valid = (fifo_count != 0); out_data shows the head entry whenever out_valid=1 (show-ahead).
- REQ-028: out_data is don't-care while out_valid=0.
- REQ-029: A pop occurs on an edge with out_valid=1 and out_ready=1.
- REQ-030: out_ready with an empty FIFO has no effect.
- REQ-031: Push and pop on the same edge leave fifo_count unchanged and preserve order.
- REQ-032: Full status is evaluated from fifo_count before the edge; a same-cycle pop does not enable a push at full.
- REQ-033: Read and write pointers wrap modulo DEPTH.
- REQ-034: fifo_count never exceeds DEPTH and never underflows.
- REQ-035: flush empties the FIFO on the next edge, overriding push and pop in that cycle.
- REQ-036: flush does not affect the FSM, the counters or the rx_* pulses.
- REQ-037: Counters saturate at 2^CNT_W-1.
- REQ-038: stat_clear forces both counters to 0, overriding a coincident increment.

Reset
- REQ-039: reset=1 immediately forces state IDLE, FIFO empty (pointers 0), fifo_count=0, out_valid=0, rx_readdata=0, rx_clearerr=0, framing_cnt=0, overrun_cnt=0.
- REQ-040: Reset mid-operation discards FIFO contents and any in-progress WAIT; after release, a byte still held by the receiver (rx_dataready=1) is handled as a new IDLE arrival.

Verification
- REQ-041: Byte 55h arrives, out_ready=0 -> one rx_readdata pulse, fifo_count=1, out_valid=1, out_data=55h; pop -> fifo_count=0.
- REQ-042: DEPTH=16; push bytes 00h..10h (17 bytes) with no pops -> first 16 stored, fifo_count=16; 17th never acknowledged; after one pop it is acknowledged, and 16 pops return 01h..10h in order.
- REQ-043: Framing-error byte 70h -> rx_readdata and rx_clearerr pulse together, FIFO unchanged, framing_cnt=1.
- REQ-044: Byte AAh with rx_overrun=1 -> AAh pushed, rx_clearerr pulses, overrun_cnt=1; stat_clear -> both counters 0.
- REQ-045: FIFO holding 3 bytes, push and pop on the same edge -> fifo_count stays 3; flush -> fifo_count=0, out_valid=0.
- REQ-046: Assert reset while in WAIT with 5 bytes queued -> all outputs 0 immediately; after release with rx_dataready=1, exactly one acknowledge and fifo_count=1.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: drains a UART receiver into a show-ahead byte FIFO with saturating error counters
module uart_rx_ctrl #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_dataready,
  input  logic                     rx_framing,
  input  logic                     rx_overrun,
  output logic                     rx_readdata,
  output logic                     rx_clearerr,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         framing_cnt,
  output logic [CNT_W-1:0]         overrun_cnt,
  input  logic                     flush,
  input  logic                     stat_clear
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic arrive, fr_ev, push, pop, ov_ev, full;
  assign arrive = (state == IDLE) && rx_dataready;
  assign full = fifo_count == (AW+1)'(DEPTH);
  assign fr_ev = arrive && rx_framing;
  assign push = arrive && !rx_framing && !full;
  assign ov_ev = (fr_ev || push) && rx_overrun;
  assign pop = out_valid && out_ready;
  assign out_valid = fifo_count != '0;
  assign out_data = mem[rp];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      rx_readdata <= 1'b0;
      rx_clearerr <= 1'b0;
      framing_cnt <= '0;
      overrun_cnt <= '0;
    end else begin
      rx_readdata <= fr_ev || push;
      rx_clearerr <= fr_ev || ov_ev;
      state <= (fr_ev || push) ? WAIT : (state == WAIT && !rx_dataready) ? IDLE : state;
      wp <= flush ? '0 : wp + AW'(push);
      rp <= flush ? '0 : rp + AW'(pop);
      fifo_count <= flush ? '0 : fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      framing_cnt <= stat_clear ? '0 : (fr_ev && !(&framing_cnt)) ? framing_cnt + CNT_W'(1) : framing_cnt;
      overrun_cnt <= stat_clear ? '0 : (ov_ev && !(&overrun_cnt)) ? overrun_cnt + CNT_W'(1) : overrun_cnt;
    end
  end
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wp] <= rx_data;
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scenarios plus a randomized receiver/consumer scored against a byte-queue model
module tb_uart_rx_ctrl;
  logic clock = 0, reset = 1;
  logic [7:0] rx_data = 0;
  logic rx_dataready = 0, rx_framing = 0, rx_overrun = 0;
  logic rx_readdata, rx_clearerr, out_valid;
  logic [7:0] out_data;
  logic out_ready = 0, flush = 0, stat_clear = 0;
  logic [4:0] fifo_count;
  logic [7:0] framing_cnt, overrun_cnt;
  int n_cmp = 0, n_fail = 0;
  bit mon_en = 0, rand_en = 0;
  logic [7:0] exp_q[$];
  int fc = 0, oc = 0;

  uart_rx_ctrl #(.DEPTH(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_dataready(rx_dataready),
    .rx_framing(rx_framing), .rx_overrun(rx_overrun), .rx_readdata(rx_readdata),
    .rx_clearerr(rx_clearerr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .framing_cnt(framing_cnt),
    .overrun_cnt(overrun_cnt), .flush(flush), .stat_clear(stat_clear));

  always #5 clock = ~clock;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(logic [7:0] d, bit fr, bit ov);
    rx_data = d; rx_framing = fr; rx_overrun = ov; rx_dataready = 1;
    tick();
    rx_dataready = 0; rx_framing = 0; rx_overrun = 0;
    tick();
  endtask

  function automatic int sat(int v);
    return v > 255 ? 255 : v;
  endfunction

  // Scoreboard: occupancy must match the model queue; every pop must return the oldest pushed byte
  always @(negedge clock) begin
    if (mon_en) begin
      check("mon_count", int'(fifo_count), exp_q.size());
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL mon_pop: got %0h expected no data (model empty)", out_data);
        end else check("mon_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clock) begin
    if (rand_en) begin
      #1;
      out_ready = ($urandom % 3) != 0;
    end
  end

  initial begin
    #2;
    check("rst_count", int'(fifo_count), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_readdata", int'(rx_readdata), 0);
    check("rst_clearerr", int'(rx_clearerr), 0);
    check("rst_framing_cnt", int'(framing_cnt), 0);
    check("rst_overrun_cnt", int'(overrun_cnt), 0);
    @(posedge clock); #1; reset = 0;
    tick();
    // single byte
    rx_data = 8'h55; rx_dataready = 1;
    tick();
    check("b55_readdata", int'(rx_readdata), 1);
    check("b55_clearerr", int'(rx_clearerr), 0);
    check("b55_count", int'(fifo_count), 1);
    check("b55_valid", int'(out_valid), 1);
    check("b55_data", int'(out_data), 8'h55);
    rx_dataready = 0;
    tick();
    check("b55_pulse_once", int'(rx_readdata), 0);
    out_ready = 1; tick(); out_ready = 0;
    check("b55_popped", int'(fifo_count), 0);
    check("b55_empty", int'(out_valid), 0);
    // framing error byte
    rx_data = 8'h70; rx_framing = 1; rx_dataready = 1;
    tick();
    check("fr_readdata", int'(rx_readdata), 1);
    check("fr_clearerr", int'(rx_clearerr), 1);
    check("fr_count", int'(fifo_count), 0);
    check("fr_cnt", int'(framing_cnt), 1);
    rx_dataready = 0; rx_framing = 0;
    tick();
    // overrun byte
    rx_data = 8'hAA; rx_overrun = 1; rx_dataready = 1;
    tick();
    check("ov_readdata", int'(rx_readdata), 1);
    check("ov_clearerr", int'(rx_clearerr), 1);
    check("ov_count", int'(fifo_count), 1);
    check("ov_data", int'(out_data), 8'hAA);
    check("ov_cnt", int'(overrun_cnt), 1);
    rx_dataready = 0; rx_overrun = 0;
    tick();
    stat_clear = 1; tick(); stat_clear = 0;
    check("sc_framing", int'(framing_cnt), 0);
    check("sc_overrun", int'(overrun_cnt), 0);
    out_ready = 1; tick(); out_ready = 0;
    // fill to full, 17th byte held off
    for (int i = 0; i < 16; i++) send(8'(i), 0, 0);
    check("full_count", int'(fifo_count), 16);
    rx_data = 8'h10; rx_dataready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_ack", int'(rx_readdata), 0);
    end
    check("full_hold", int'(fifo_count), 16);
    check("full_head", int'(out_data), 0);
    out_ready = 1; tick(); out_ready = 0;
    check("full_pop_no_push", int'(rx_readdata), 0);
    check("full_after_pop", int'(fifo_count), 15);
    tick();
    check("full_late_ack", int'(rx_readdata), 1);
    check("full_refill", int'(fifo_count), 16);
    rx_dataready = 0;
    tick();
    for (int i = 1; i <= 16; i++) begin
      check("full_order", int'(out_data), i);
      out_ready = 1; tick(); out_ready = 0;
    end
    check("full_drained", int'(fifo_count), 0);
    // push+pop on same edge, then flush
    send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0);
    rx_data = 8'h44; rx_dataready = 1; out_ready = 1;
    tick();
    out_ready = 0;
    check("pp_ack", int'(rx_readdata), 1);
    check("pp_count", int'(fifo_count), 3);
    check("pp_head", int'(out_data), 8'h22);
    rx_dataready = 0;
    tick();
    flush = 1; tick(); flush = 0;
    check("flush_count", int'(fifo_count), 0);
    check("flush_valid", int'(out_valid), 0);
    // reset while in WAIT with 5 queued
    for (int i = 0; i < 4; i++) send(8'h80 + 8'(i), 0, 0);
    rx_data = 8'h99; rx_dataready = 1;
    tick();
    check("pre_rst_count", int'(fifo_count), 5);
    #1 reset = 1;
    #1;
    check("arst_count", int'(fifo_count), 0);
    check("arst_valid", int'(out_valid), 0);
    check("arst_readdata", int'(rx_readdata), 0);
    tick();
    reset = 0;
    tick();
    check("post_rst_ack", int'(rx_readdata), 1);
    check("post_rst_count", int'(fifo_count), 1);
    check("post_rst_data", int'(out_data), 8'h99);
    tick();
    check("post_rst_single", int'(rx_readdata), 0);
    check("post_rst_count2", int'(fifo_count), 1);
    rx_dataready = 0; tick();
    out_ready = 1; tick(); out_ready = 0;
    // framing counter saturation and stat_clear priority
    for (int i = 0; i < 260; i++) send(8'h00, 1, 0);
    check("sat_framing", int'(framing_cnt), 255);
    check("sat_fifo", int'(fifo_count), 0);
    rx_framing = 1; rx_dataready = 1; stat_clear = 1;
    tick();
    stat_clear = 0; rx_framing = 0; rx_dataready = 0;
    check("sc_priority_ack", int'(rx_readdata), 1);
    check("sc_priority", int'(framing_cnt), 0);
    tick();
    // randomized phase
    mon_en = 1; rand_en = 1;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] d;
      bit fr, ov, got;
      d = 8'($urandom);
      fr = ($urandom % 8) == 0;
      ov = ($urandom % 6) == 0;
      rx_data = d; rx_framing = fr; rx_overrun = ov; rx_dataready = 1;
      got = 0;
      for (int w = 0; w < 300 && !got; w++) begin
        tick();
        got = rx_readdata;
      end
      check("rand_ack", int'(got), 1);
      if (!got) break;
      check("rand_clearerr", int'(rx_clearerr), int'(fr | ov));
      if (!fr) exp_q.push_back(d);
      fc = sat(fc + int'(fr));
      oc = sat(oc + int'(ov));
      rx_dataready = 0; rx_framing = 0; rx_overrun = 0;
      repeat ($urandom_range(1, 3)) tick();
    end
    rand_en = 0;
    tick();
    out_ready = 1;
    for (int w = 0; w < 100 && exp_q.size() != 0; w++) tick();
    out_ready = 0;
    tick();
    mon_en = 0;
    check("rand_drained", int'(fifo_count), 0);
    check("rand_model_empty", exp_q.size(), 0);
    check("rand_framing_cnt", int'(framing_cnt), fc);
    check("rand_overrun_cnt", int'(overrun_cnt), oc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
